dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter and access sequencer for the 256 x 16 synchronous Data Memory. It sits between the Data Memory and two requesters: the processor's control unit (Load/Store traffic) and a debug/loader port used to preload or dump memory. It serialises their accesses, drives the single memory port, and returns read data with a valid strobe.

## Interface
Parameters:
- ADDR_W, 8, Data Memory address width
- DATA_W, 16, Data Memory word width

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-low; forces IDLE immediately
- cpu_req  in  1  CPU access request; hold high with fields stable until cpu_gnt
- cpu_wr  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU word address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_gnt  out  1  one-cycle pulse: CPU access issued this cycle
- cpu_rvalid  out  1  one-cycle pulse: cpu_rdata valid
- cpu_rdata  out  DATA_W  read data; 0 when cpu_rvalid is low
- dbg_req, dbg_wr, dbg_addr, dbg_wdata  in  1/1/ADDR_W/DATA_W  debug port, same rules as the CPU fields
- dbg_gnt, dbg_rvalid, dbg_rdata  out  1/1/DATA_W  debug port, same rules as the CPU fields
- mem_addr  out  ADDR_W  Data Memory address
- mem_wr  out  1  Data Memory write enable
- mem_wdata  out  DATA_W  Data Memory write data
- mem_rdata  in  DATA_W  Data Memory read data, one cycle after the address is captured
- arb_state  out  2  current FSM state for board display: IDLE=0, ISSUE=1, RDATA=2

## Operation
- The FSM has three states: IDLE, ISSUE and RDATA. Encoding 3 is unreachable and recovers to IDLE.
- IDLE
  - Requests are sampled only in IDLE.
  - If any request is high, the arbiter selects a winner and latches the owner, wr, addr and wdata at the clock edge, then moves to ISSUE.
  - With no request it stays in IDLE.
- ISSUE
  - mem_addr and mem_wdata come from the latched fields. mem_wr = latched wr.
  - The owner's gnt is 1 for exactly this cycle.
  - Next state is RDATA for a read and IDLE for a write.
- RDATA
  - The owner's rvalid is 1 and its rdata = mem_rdata.
  - The other port's rdata is 0.
  - Next state is IDLE.
- After seeing gnt, a requester either drops req or presents a new request in the following cycle. Because requests are sampled only in IDLE, a request held through a read's RDATA cycle is sampled again in IDLE.
- Arbitration is round-robin by default:
  - A sole requester always wins.
  - On a tie, the port not granted last wins.
  - last_owner resets to DBG, so the first tie goes to the CPU.
- mem_addr and mem_wdata hold their latched values outside ISSUE. mem_wr is 0 outside ISSUE.

## Timing
- Reset values:
  - arb_state = IDLE
  - all gnt, rvalid and mem_wr = 0
  - mem_addr, mem_wdata and all rdata = 0
  - last_owner = DBG
- Cycle numbering: req is high in cycle 0, while the FSM is in IDLE.
- Write: ISSUE in cycle 1 (gnt=1, mem_wr=1), memory updated at edge 2, IDLE in cycle 2. Occupancy is 2 cycles per write.
- Read: ISSUE in cycle 1 (gnt=1), RDATA in cycle 2 (rvalid=1, rdata valid), IDLE in cycle 3. Occupancy is 3 cycles per read.
- Two back-to-back contending requesters alternate grants under round-robin. The maximum wait is one access of the other port.
- Reset asserted mid-operation:
  - The FSM goes to IDLE asynchronously and mem_wr drops immediately, so a write is aborted if reset precedes the edge.
  - A pending read returns no rvalid.
  - last_owner returns to DBG.
- A requester deasserting req in IDLE before the sampling edge gets no access and no gnt.

## Configuration
- DMEM_ARB_FIXED_PRIO_EN
  - Defined: fixed priority, the CPU always wins a tie and last_owner is not used. The debug port is served only when cpu_req is low in IDLE.
  - Undefined: round-robin as in Operation.

## Test plan
- Reset held low, then released → all outputs 0, arb_state=0. cpu_req=1, wr=1, addr=8'd205, wdata=16'h00A5 → cpu_gnt and mem_wr high for one cycle with mem_addr=205, then arb_state returns to 0.
- CPU read of addr 11 with memory word 11 = 16'h1234 → gnt in cycle 1 → cpu_rvalid=1 and cpu_rdata=16'h1234 in cycle 2 → dbg_rdata=0 throughout.
- cpu_req and dbg_req both held high with alternating reads → grant order CPU, DBG, CPU, DBG. With DMEM_ARB_FIXED_PRIO_EN defined → CPU granted every time and dbg_gnt never asserts while cpu_req is high.
- Only dbg_req high (write 16'hBEEF to addr 138), then a CPU read of addr 138 → cpu_rdata=16'hBEEF.
- reset pulsed low during RDATA of a CPU read → arb_state=0 immediately, no cpu_rvalid. The next request is served normally, with the CPU winning the first tie.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port (CPU / debug) arbiter and access sequencer for the
// 256 x 16 synchronous Data Memory. Requests are sampled only in IDLE; the
// winner's fields are latched and issued for one cycle, and reads return the
// memory word one cycle later with a valid strobe.
//
// Build option: define DMEM_ARB_FIXED_PRIO_EN for fixed priority (CPU always
// wins a tie). Left undefined, ties are resolved round-robin.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | no access in flight; requests sampled, winner latched
//   ISSUE | latched access driven to memory; owner's gnt pulses
//   RDATA | read word returned to owner with rvalid
module dmem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              cpu_req_i,
  input  logic              cpu_wr_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic              cpu_gnt_o,
  output logic              cpu_rvalid_o,
  output logic [DATA_W-1:0] cpu_rdata_o,
  input  logic              dbg_req_i,
  input  logic              dbg_wr_i,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  input  logic [DATA_W-1:0] dbg_wdata_i,
  output logic              dbg_gnt_o,
  output logic              dbg_rvalid_o,
  output logic [DATA_W-1:0] dbg_rdata_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_wr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic [1:0]        arb_state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RDATA = 2'd2
  } state_e;

  // Owner encoding: 0 = CPU, 1 = debug port.
  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DBG = 1'b1;

  state_e              state_q, state_d;
  logic                owner_q, owner_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                any_req;
  logic                win_dbg;
  logic                in_issue;
  logic                in_rdata;

  assign any_req = cpu_req_i | dbg_req_i;

`ifdef DMEM_ARB_FIXED_PRIO_EN
  // Debug port is only served when the CPU is not asking.
  assign win_dbg = ~cpu_req_i;
`else
  logic last_q;

  // A sole requester wins; on a tie the port not granted last wins.
  assign win_dbg = dbg_req_i & (~cpu_req_i | (last_q == OWN_CPU));

  // Remember the most recent winner; reset favours the CPU on the first tie.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      last_q <= OWN_DBG;
    end else if (state_q == IDLE && any_req) begin
      last_q <= win_dbg;
    end
  end
`endif

  // State and latched-request registers.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      owner_q <= OWN_CPU;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Next-state logic; the winner's fields are captured when leaving IDLE.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          owner_d = win_dbg;
          wr_d    = win_dbg ? dbg_wr_i    : cpu_wr_i;
          addr_d  = win_dbg ? dbg_addr_i  : cpu_addr_i;
          wdata_d = win_dbg ? dbg_wdata_i : cpu_wdata_i;
          state_d = ISSUE;
        end
      end
      ISSUE:   state_d = wr_q ? IDLE : RDATA;
      RDATA:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode from the current state so reset silences them at once.
  always_comb begin
    in_issue     = (state_q == ISSUE);
    in_rdata     = (state_q == RDATA);
    cpu_gnt_o    = in_issue & (owner_q == OWN_CPU);
    dbg_gnt_o    = in_issue & (owner_q == OWN_DBG);
    cpu_rvalid_o = in_rdata & (owner_q == OWN_CPU);
    dbg_rvalid_o = in_rdata & (owner_q == OWN_DBG);
    cpu_rdata_o  = cpu_rvalid_o ? mem_rdata_i : '0;
    dbg_rdata_o  = dbg_rvalid_o ? mem_rdata_i : '0;
    mem_wr_o     = in_issue & wr_q;
    mem_addr_o   = addr_q;
    mem_wdata_o  = wdata_q;
    arb_state_o  = state_q;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a 256 x 16 synchronous memory, a transaction-level
// reference model that schedules expected outputs by access occupancy, and
// directed plus random requester traffic.
module tb_dmem_arbiter;

  localparam int AW = 8;
  localparam int DW = 16;

  logic          clk;
  logic          rst_n;
  logic          cpu_req, cpu_wr, dbg_req, dbg_wr;
  logic [AW-1:0] cpu_addr, dbg_addr, mem_addr;
  logic [DW-1:0] cpu_wdata, dbg_wdata, mem_wdata, mem_rdata;
  logic          cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid, mem_wr;
  logic [DW-1:0] cpu_rdata, dbg_rdata;
  logic [1:0]    arb_state;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i(clk), .reset_ni(rst_n),
    .cpu_req_i(cpu_req), .cpu_wr_i(cpu_wr), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_gnt_o(cpu_gnt), .cpu_rvalid_o(cpu_rvalid), .cpu_rdata_o(cpu_rdata),
    .dbg_req_i(dbg_req), .dbg_wr_i(dbg_wr), .dbg_addr_i(dbg_addr), .dbg_wdata_i(dbg_wdata),
    .dbg_gnt_o(dbg_gnt), .dbg_rvalid_o(dbg_rvalid), .dbg_rdata_o(dbg_rdata),
    .mem_addr_o(mem_addr), .mem_wr_o(mem_wr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata), .arb_state_o(arb_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data Memory: write on the edge, registered read of the presented address.
  logic [DW-1:0] dmem [0:255];
  always @(posedge clk) begin
    if (mem_wr) dmem[mem_addr] <= mem_wdata;
    mem_rdata <= dmem[mem_addr];
  end

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [1:0]    st;
    logic          gc, gd, wr, rc, rd;
    logic [DW-1:0] rdata;
  } exp_t;

  logic [DW-1:0] ref_mem [0:255];
  exp_t          ring [4];
  int            cyc, free_at;
  bit            last_dbg;
  logic [AW-1:0] lat_addr;
  logic [DW-1:0] lat_wdata;
  bit            cur_gc, cur_gd;
  bit            fixed_prio;
  int            n_cmp, n_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) ring[i] = '0;
    free_at   = cyc;
    last_dbg  = 1'b1;
    lat_addr  = '0;
    lat_wdata = '0;
    cur_gc    = 1'b0;
    cur_gd    = 1'b0;
  endtask

  // Decide what the current inputs cause, scheduling outputs for later cycles.
  task automatic model_eval();
    bit            win, w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            k1, k2;
    if (cyc >= free_at && (cpu_req || dbg_req)) begin
      if (fixed_prio)              win = !cpu_req;
      else if (cpu_req && dbg_req) win = !last_dbg;
      else                         win = dbg_req;
      last_dbg = win;
      w = win ? dbg_wr    : cpu_wr;
      a = win ? dbg_addr  : cpu_addr;
      d = win ? dbg_wdata : cpu_wdata;
      k1 = (cyc + 1) % 4;
      ring[k1].st = 2'd1;
      ring[k1].gc = !win;
      ring[k1].gd = win;
      ring[k1].wr = w;
      lat_addr  = a;
      lat_wdata = d;
      if (w) begin
        ref_mem[a] = d;
        free_at = cyc + 2;
      end else begin
        k2 = (cyc + 2) % 4;
        ring[k2].st    = 2'd2;
        ring[k2].rc    = !win;
        ring[k2].rd    = win;
        ring[k2].rdata = ref_mem[a];
        free_at = cyc + 3;
      end
    end
  endtask

  task automatic compare();
    exp_t e;
    int   k;
    k = cyc % 4;
    e = ring[k];
    chk("arb_state",  {30'd0, arb_state}, {30'd0, e.st});
    chk("cpu_gnt",    {31'd0, cpu_gnt},    {31'd0, e.gc});
    chk("dbg_gnt",    {31'd0, dbg_gnt},    {31'd0, e.gd});
    chk("mem_wr",     {31'd0, mem_wr},     {31'd0, e.wr});
    chk("mem_addr",   {24'd0, mem_addr},   {24'd0, lat_addr});
    chk("mem_wdata",  {16'd0, mem_wdata},  {16'd0, lat_wdata});
    chk("cpu_rvalid", {31'd0, cpu_rvalid}, {31'd0, e.rc});
    chk("dbg_rvalid", {31'd0, dbg_rvalid}, {31'd0, e.rd});
    chk("cpu_rdata",  {16'd0, cpu_rdata},  {16'd0, e.rc ? e.rdata : 16'd0});
    chk("dbg_rdata",  {16'd0, dbg_rdata},  {16'd0, e.rd ? e.rdata : 16'd0});
    cur_gc = e.gc;
    cur_gd = e.gd;
    ring[k] = '0;
  endtask

  task automatic cycle();
    model_eval();
    @(posedge clk);
    #1;
    cyc++;
    compare();
  endtask

  task automatic set_cpu(input bit req, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cpu_req = req; cpu_wr = wr; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic set_dbg(input bit req, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    dbg_req = req; dbg_wr = wr; dbg_addr = a; dbg_wdata = d;
  endtask

  task automatic rand_fields(output bit wr, output logic [AW-1:0] a, output logic [DW-1:0] d);
    wr = ($urandom_range(0, 1) == 1);
    a  = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 255)) : AW'($urandom_range(0, 15));
    d  = DW'($urandom);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int            order[$];
    bit            after_c, after_d, w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [DW-1:0] v;

    n_cmp = 0; n_err = 0; cyc = 0;
`ifdef DMEM_ARB_FIXED_PRIO_EN
    fixed_prio = 1'b1;
`else
    fixed_prio = 1'b0;
`endif
    for (int i = 0; i < 256; i++) begin
      v = DW'($urandom);
      dmem[i] = v;
      ref_mem[i] = v;
    end
    dmem[11] = 16'h1234;
    ref_mem[11] = 16'h1234;

    rst_n = 1'b0;
    set_cpu(0, 0, '0, '0);
    set_dbg(0, 0, '0, '0);
    model_reset();
    #7;
    chk("rst arb_state", {30'd0, arb_state}, 32'd0);
    chk("rst gnt/rvalid/wr", {28'd0, cpu_gnt, dbg_gnt, mem_wr, cpu_rvalid | dbg_rvalid}, 32'd0);
    chk("rst mem_addr/wdata", {8'd0, mem_addr, mem_wdata}, 32'd0);
    chk("rst rdata", {cpu_rdata, dbg_rdata}, 32'd0);
    #16 rst_n = 1'b1;

    // CPU write of 16'h00A5 to address 205.
    set_cpu(1, 1, 8'd205, 16'h00A5);
    cycle();
    chk("wr205 cpu_gnt", {31'd0, cpu_gnt}, 32'd1);
    chk("wr205 mem_wr", {31'd0, mem_wr}, 32'd1);
    chk("wr205 mem_addr", {24'd0, mem_addr}, 32'd205);
    cpu_req = 1'b0;
    cycle();
    chk("wr205 back to idle", {30'd0, arb_state}, 32'd0);
    chk("wr205 memory word", {16'd0, dmem[205]}, 32'h00A5);

    // CPU read of address 11.
    set_cpu(1, 0, 8'd11, 16'h0);
    cycle();
    chk("rd11 cpu_gnt", {31'd0, cpu_gnt}, 32'd1);
    cpu_req = 1'b0;
    cycle();
    chk("rd11 cpu_rvalid", {31'd0, cpu_rvalid}, 32'd1);
    chk("rd11 cpu_rdata", {16'd0, cpu_rdata}, 32'h1234);
    chk("rd11 dbg_rdata", {16'd0, dbg_rdata}, 32'd0);
    cycle();

    // Debug write of 16'hBEEF to address 138 (debug becomes last owner).
    set_dbg(1, 1, 8'd138, 16'hBEEF);
    cycle();
    chk("dbgwr dbg_gnt", {31'd0, dbg_gnt}, 32'd1);
    dbg_req = 1'b0;
    cycle();

    // Both ports hold read requests: four grants.
    set_cpu(1, 0, 8'd3, 16'h0);
    set_dbg(1, 0, 8'd4, 16'h0);
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (cpu_gnt) order.push_back(0);
      if (dbg_gnt) order.push_back(1);
    end
    cpu_req = 1'b0;
    dbg_req = 1'b0;
    chk("tie grant count", order.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < order.size())
        chk($sformatf("tie grant %0d owner", i), order[i], fixed_prio ? 32'd0 : 32'(i % 2));
    end
    cycle();

    // CPU read back of the debug write.
    set_cpu(1, 0, 8'd138, 16'h0);
    cycle();
    cpu_req = 1'b0;
    cycle();
    chk("rd138 cpu_rdata", {16'd0, cpu_rdata}, 32'hBEEF);
    cycle();

    // Debug request withdrawn before the sampling edge.
    set_dbg(1, 1, 8'd77, 16'h5555);
    #2 dbg_req = 1'b0;
    cycle();
    chk("withdrawn dbg_gnt", {31'd0, dbg_gnt}, 32'd0);
    chk("withdrawn mem_wr", {31'd0, mem_wr}, 32'd0);

    // Reset pulsed during RDATA of a CPU read.
    set_cpu(1, 0, 8'd20, 16'h0);
    cycle();
    cpu_req = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst arb_state", {30'd0, arb_state}, 32'd0);
    chk("midrst cpu_rvalid", {31'd0, cpu_rvalid}, 32'd0);
    chk("midrst cpu_rdata", {16'd0, cpu_rdata}, 32'd0);
    model_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
    cycle();

    // First tie after reset goes to the CPU.
    set_cpu(1, 1, 8'd30, 16'h1111);
    set_dbg(1, 1, 8'd31, 16'h2222);
    cycle();
    chk("postrst tie cpu_gnt", {31'd0, cpu_gnt}, 32'd1);
    chk("postrst tie dbg_gnt", {31'd0, dbg_gnt}, 32'd0);
    cpu_req = 1'b0;
    cycle();
    cycle();
    chk("postrst dbg served", {31'd0, dbg_gnt}, 32'd1);
    dbg_req = 1'b0;
    cycle();

    // Random traffic obeying the request/grant handshake.
    after_c = 1'b0;
    after_d = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (after_c) begin
        if ($urandom_range(0, 1) == 1) begin
          rand_fields(w, a, d);
          set_cpu(1, w, a, d);
        end else cpu_req = 1'b0;
      end else if (!cpu_req && $urandom_range(0, 2) == 0) begin
        rand_fields(w, a, d);
        set_cpu(1, w, a, d);
      end
      if (after_d) begin
        if ($urandom_range(0, 1) == 1) begin
          rand_fields(w, a, d);
          set_dbg(1, w, a, d);
        end else dbg_req = 1'b0;
      end else if (!dbg_req && $urandom_range(0, 2) == 0) begin
        rand_fields(w, a, d);
        set_dbg(1, w, a, d);
      end
      cycle();
      after_c = cur_gc;
      after_d = cur_gd;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
